i2c_slave_ctrl: RTL

//   Byte-level I2C slave protocol controller for the LED driver.
//   - Sits between the bit-level bus interface and the LED register bank.
//   - Sequences address match, register-pointer load, register writes and register reads.
//   - Owns an auto-incrementing register file whose contents drive the PWM/LED logic.

---
 rtl/i2c_ctrl_pkg.sv | 19 +
 rtl/i2c_reg_file.sv | 39 +++
 rtl/i2c_slave_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/i2c_ctrl_pkg.sv
// Shared types and constants for the I2C slave controller and its register bank.
package i2c_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_PTR,
    ST_WRITE,
    ST_RD_LOAD,
    ST_RD_WAIT,
    ST_IGNORE
  } state_t;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h40;

endpackage

// File: rtl/i2c_reg_file.sv
// NUM_REGS x 8 register bank: one synchronous write port, combinational read,
// flattened view of every register for the LED/PWM logic.
module i2c_reg_file #(
  parameter  int unsigned NUM_REGS = 16,
  localparam int unsigned PTR_W    = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [PTR_W-1:0]      waddr,
  input  logic [7:0]            wdata,
  input  logic [PTR_W-1:0]      raddr,
  output logic [7:0]            rdata,
  output logic [NUM_REGS*8-1:0] regs_flat
);

  logic [7:0] regs_q [NUM_REGS];
  logic [7:0] regs_d [NUM_REGS];

  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      regs_q[i] <= reset ? '0 : regs_d[i];
    end
  end

  always_comb begin
    rdata     = regs_q[raddr];
    regs_flat = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      regs_flat[8*i +: 8] = regs_q[i];
    end
  end

endmodule

// File: rtl/i2c_slave_ctrl.sv
// Byte-level I2C slave controller: address match, pointer load, auto-incrementing
// register writes and streamed register reads on top of the bus bit engine.
module i2c_slave_ctrl
  import i2c_ctrl_pkg::*;
#(
  parameter  logic [6:0]  DEV_ADDR = DEFAULT_DEV_ADDR,
  parameter  int unsigned NUM_REGS = 16,
  localparam int unsigned PTR_W    = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  bus_start,
  input  logic                  bus_stop,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  tx_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_req,
  output logic                  ack_req,
  output logic [NUM_REGS*8-1:0] regs_flat,
  output logic                  reg_wr_stb,
  output logic [PTR_W-1:0]      reg_wr_addr,
  output logic                  busy
);

  state_t           state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_req_q, tx_req_d;
  logic             ack_req_q, ack_req_d;
  logic             tx_ready_prev_q;
  logic             wr_en;
  logic [7:0]       rd_data;

  i2c_reg_file #(.NUM_REGS(NUM_REGS)) u_regs (
    .clk      (clk),
    .reset    (reset),
    .we       (wr_en),
    .waddr    (ptr_q),
    .wdata    (rx_data),
    .raddr    (ptr_q),
    .rdata    (rd_data),
    .regs_flat(regs_flat)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      ptr_q           <= '0;
      tx_data_q       <= '0;
      tx_req_q        <= 1'b0;
      ack_req_q       <= 1'b0;
      tx_ready_prev_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      ptr_q           <= ptr_d;
      tx_data_q       <= tx_data_d;
      tx_req_q        <= tx_req_d;
      ack_req_q       <= ack_req_d;
      tx_ready_prev_q <= tx_ready;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    tx_data_d = tx_data_q;
    tx_req_d  = 1'b0;
    ack_req_d = 1'b0;
    wr_en     = 1'b0;
    // START outranks STOP, which outranks any byte arriving in the same cycle.
    if (bus_start) begin
      state_d = ST_ADDR;
    end else if (bus_stop) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_ADDR: if (rx_valid) begin
          if (rx_data[7:1] == DEV_ADDR) begin
            ack_req_d = 1'b1;
            state_d   = (rx_data[0] == RW_READ) ? ST_RD_LOAD : ST_PTR;
          end else begin
            state_d = ST_IGNORE;
          end
        end
        ST_PTR: if (rx_valid) begin
          if (32'(rx_data) < NUM_REGS) begin
            ptr_d     = rx_data[PTR_W-1:0];
            ack_req_d = 1'b1;
            state_d   = ST_WRITE;
          end else begin
            state_d = ST_IGNORE;
          end
        end
        ST_WRITE: if (rx_valid) begin
          wr_en     = 1'b1;
          ack_req_d = 1'b1;
          ptr_d     = ptr_q + PTR_W'(1);
        end
        ST_RD_LOAD: if (tx_ready) begin
          tx_data_d = rd_data;
          tx_req_d  = 1'b1;
          ptr_d     = ptr_q + PTR_W'(1);
          state_d   = ST_RD_WAIT;
        end
        ST_RD_WAIT: if (tx_ready && !tx_ready_prev_q) begin
          state_d = ST_RD_LOAD;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    tx_data     = tx_data_q;
    tx_req      = tx_req_q;
    ack_req     = ack_req_q;
    reg_wr_stb  = wr_en & ~reset;
    reg_wr_addr = ptr_q;
    busy        = (state_q != ST_IDLE);
  end

endmodule
